// File: rtl/jogo_memoria_pkg.sv
// Shared state codes, LFSR constants and helpers for the memory-sequence game.
package jogo_memoria_pkg;

    typedef logic [3:0] estado_t;

    localparam estado_t S_INICIAL    = 4'd0;
    localparam estado_t S_PREPARA    = 4'd1;
    localparam estado_t S_MOSTRA     = 4'd2;
    localparam estado_t S_ESPERA     = 4'd3;
    localparam estado_t S_COMPARA    = 4'd4;
    localparam estado_t S_FIM_RODADA = 4'd5;
    localparam estado_t S_GANHOU     = 4'd6;
    localparam estado_t S_PERDEU     = 4'd7;
    localparam estado_t S_TIMEOUT    = 4'd8;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] SEMENTE_NULA = 16'h0001;

    function automatic logic [15:0] lfsr_passo(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/gerador_sequencia.sv
// Seeded LFSR sequence source: keeps the round base and the running state,
// exposing the current element one-hot.
module gerador_sequencia
    import jogo_memoria_pkg::*;
#(
    parameter int unsigned NUM_BOTOES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_carrega_base,
    input  logic                  i_recarrega,
    input  logic                  i_passo,
    input  logic [15:0]           i_semente,
    output logic [NUM_BOTOES-1:0] o_elemento_c
);

    localparam int unsigned W_SEL = $clog2(NUM_BOTOES);

    logic [15:0] r_base;
    logic [15:0] r_lfsr;
    logic [15:0] w_semente;

    // An all-zero seed would lock the LFSR, so it is replaced.
    assign w_semente = (i_semente == 16'h0000) ? SEMENTE_NULA : i_semente;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= 16'h0000;
            r_lfsr <= 16'h0000;
        end else if (i_carrega_base) begin
            r_base <= w_semente;
            r_lfsr <= w_semente;
        end else if (i_recarrega) begin
            r_lfsr <= r_base;
        end else if (i_passo) begin
            r_lfsr <= lfsr_passo(r_lfsr);
        end
    end

    assign o_elemento_c = NUM_BOTOES'(onehot(4'(r_lfsr[W_SEL-1:0])));

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-sequence game: plays the LFSR-generated prefix on the LEDs each round,
// then checks button presses against it with a per-press timeout.
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int unsigned NUM_BOTOES     = 4,
    parameter int unsigned PROFUNDIDADE   = 16,
    parameter int unsigned TIMEOUT_CICLOS = 3000,
    parameter int unsigned MOSTRA_CICLOS  = 500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jogar,
    input  logic [NUM_BOTOES-1:0] botoes,
    input  logic [15:0]           semente,
    input  logic                  nivel,
    output logic [NUM_BOTOES-1:0] leds,
    output logic                  ganhou,
    output logic                  perdeu,
    output logic                  timeout,
    output logic                  pronto,
    output logic [3:0]            db_estado,
    output logic [7:0]            db_rodada,
    output logic [7:0]            db_indice
);

    localparam int unsigned MAX_CNT = (TIMEOUT_CICLOS > MOSTRA_CICLOS) ? TIMEOUT_CICLOS : MOSTRA_CICLOS;
    localparam int unsigned W_CNT   = $clog2(MAX_CNT + 1);
    localparam int unsigned W_IND   = $clog2(PROFUNDIDADE);
    localparam int unsigned W_ROD   = $clog2(PROFUNDIDADE + 1);

    estado_t               r_estado;
    logic [W_CNT-1:0]      r_cnt;
    logic [W_IND-1:0]      r_indice;
    logic [W_ROD-1:0]      r_rodada;
    logic [W_ROD-1:0]      r_limite;
    logic                  r_aceso;
    logic                  r_fim;
    logic [NUM_BOTOES-1:0] r_leds;
    logic [NUM_BOTOES-1:0] r_jogada;
    logic                  r_or_ant;
    logic                  r_armado;
    logic                  r_ganhou;
    logic                  r_perdeu;
    logic                  r_timeout;
    logic                  r_pronto;

    estado_t               w_prox;
    logic [W_CNT-1:0]      w_cnt_prox;
    logic [W_IND-1:0]      w_indice_prox;
    logic [W_ROD-1:0]      w_rodada_prox;
    logic [W_ROD-1:0]      w_limite_prox;
    logic                  w_aceso_prox;
    logic                  w_fim_prox;
    logic [NUM_BOTOES-1:0] w_leds_prox;
    logic [NUM_BOTOES-1:0] w_jogada_prox;
    logic                  w_carrega;
    logic                  w_recarrega;
    logic                  w_passo;
    logic                  w_entra_mostra;
    logic                  w_press;
    logic                  w_inicia;
    logic                  w_ultimo;
    logic [NUM_BOTOES-1:0] w_elemento;

    gerador_sequencia #(
        .NUM_BOTOES (NUM_BOTOES)
    ) u_gerador (
        .clk            (clock),
        .rst_n          (reset),
        .i_carrega_base (w_carrega),
        .i_recarrega    (w_recarrega),
        .i_passo        (w_passo),
        .i_semente      (semente),
        .o_elemento_c   (w_elemento)
    );

    // Press = rising edge of any button; a held button never re-triggers.
    assign w_press  = (|botoes) & ~r_or_ant;
    // A start consumes the arm; jogar must drop before it can start again.
    assign w_inicia = jogar & r_armado;
    assign w_ultimo = ((W_ROD'(r_indice) + W_ROD'(1)) == r_rodada);

    always_comb begin
        w_prox         = r_estado;
        w_cnt_prox     = r_cnt;
        w_indice_prox  = r_indice;
        w_rodada_prox  = r_rodada;
        w_limite_prox  = r_limite;
        w_aceso_prox   = r_aceso;
        w_fim_prox     = r_fim;
        w_leds_prox    = '0;
        w_jogada_prox  = r_jogada;
        w_carrega      = 1'b0;
        w_recarrega    = 1'b0;
        w_passo        = 1'b0;
        w_entra_mostra = 1'b0;

        case (r_estado)
            S_INICIAL: begin
                if (w_inicia) begin
                    w_prox    = S_PREPARA;
                    w_carrega = 1'b1;
                end
            end
            S_PREPARA: begin
                w_rodada_prox  = W_ROD'(1);
                w_limite_prox  = nivel ? W_ROD'(PROFUNDIDADE) : W_ROD'(PROFUNDIDADE / 2);
                w_entra_mostra = 1'b1;
            end
            S_MOSTRA: begin
                // r_fim marks the single settling cycle after the last gap.
                if (r_fim) begin
                    w_prox        = S_ESPERA;
                    w_recarrega   = 1'b1;
                    w_indice_prox = '0;
                    w_cnt_prox    = '0;
                end else if (r_cnt == W_CNT'(MOSTRA_CICLOS - 1)) begin
                    w_cnt_prox = '0;
                    if (r_aceso) begin
                        w_aceso_prox = 1'b0;
                        w_passo      = 1'b1;
                    end else if (w_ultimo) begin
                        w_fim_prox = 1'b1;
                    end else begin
                        w_indice_prox = r_indice + W_IND'(1);
                        w_aceso_prox  = 1'b1;
                        w_leds_prox   = w_elemento;
                    end
                end else begin
                    w_cnt_prox  = r_cnt + W_CNT'(1);
                    w_leds_prox = r_leds;
                end
            end
            S_ESPERA: begin
                // The flag register trails the state by one cycle, so the state
                // leaves one cycle early to land the flag on TIMEOUT_CICLOS.
                if (w_press) begin
                    w_jogada_prox = botoes;
                    w_prox        = S_COMPARA;
                end else if (r_cnt == W_CNT'(TIMEOUT_CICLOS - 2)) begin
                    w_prox = S_TIMEOUT;
                end else begin
                    w_cnt_prox = r_cnt + W_CNT'(1);
                end
            end
            S_COMPARA: begin
                // The element is one-hot, so zero or multiple bits never match.
                if (r_jogada != w_elemento) begin
                    w_prox = S_PERDEU;
                end else if (w_ultimo) begin
                    w_prox      = S_FIM_RODADA;
                    w_recarrega = 1'b1;
                end else begin
                    w_prox        = S_ESPERA;
                    w_indice_prox = r_indice + W_IND'(1);
                    w_passo       = 1'b1;
                    w_cnt_prox    = '0;
                end
            end
            S_FIM_RODADA: begin
                if (r_rodada == r_limite) begin
                    w_prox = S_GANHOU;
                end else begin
                    w_rodada_prox  = r_rodada + W_ROD'(1);
                    w_entra_mostra = 1'b1;
                end
            end
            S_GANHOU, S_PERDEU, S_TIMEOUT: begin
                if (w_inicia) begin
                    w_prox    = S_PREPARA;
                    w_carrega = 1'b1;
                end
            end
            default: begin
                w_prox = S_INICIAL;
            end
        endcase

        // The LFSR already holds the base here, so element 0 lights on entry.
        if (w_entra_mostra) begin
            w_prox        = S_MOSTRA;
            w_cnt_prox    = '0;
            w_indice_prox = '0;
            w_aceso_prox  = 1'b1;
            w_fim_prox    = 1'b0;
            w_leds_prox   = w_elemento;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= S_INICIAL;
            r_cnt     <= '0;
            r_indice  <= '0;
            r_rodada  <= '0;
            r_limite  <= '0;
            r_aceso   <= 1'b0;
            r_fim     <= 1'b0;
            r_leds    <= '0;
            r_jogada  <= '0;
            r_or_ant  <= 1'b0;
            r_armado  <= 1'b1;
            r_ganhou  <= 1'b0;
            r_perdeu  <= 1'b0;
            r_timeout <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_estado  <= w_prox;
            r_cnt     <= w_cnt_prox;
            r_indice  <= w_indice_prox;
            r_rodada  <= w_rodada_prox;
            r_limite  <= w_limite_prox;
            r_aceso   <= w_aceso_prox;
            r_fim     <= w_fim_prox;
            r_leds    <= w_leds_prox;
            r_jogada  <= w_jogada_prox;
            r_or_ant  <= |botoes;
            r_armado  <= w_carrega ? 1'b0 : (!jogar ? 1'b1 : r_armado);
            r_ganhou  <= (r_estado == S_GANHOU);
            r_perdeu  <= (r_estado == S_PERDEU);
            r_timeout <= (r_estado == S_TIMEOUT);
            r_pronto  <= (r_estado == S_GANHOU) || (r_estado == S_PERDEU) ||
                         (r_estado == S_TIMEOUT);
        end
    end

    assign leds      = r_leds;
    assign ganhou    = r_ganhou;
    assign perdeu    = r_perdeu;
    assign timeout   = r_timeout;
    assign pronto    = r_pronto;
    assign db_estado = r_estado;
    assign db_rodada = 8'(r_rodada);
    assign db_indice = 8'(r_indice);

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param: playback timing, full games at both
// levels, wrong/multiple presses, timeout, held buttons, restart and reset.
module tb_jogo_memoria_param;

    localparam int unsigned NB = 4;
    localparam int unsigned PF = 16;
    localparam int unsigned TO = 3000;
    localparam int unsigned MC = 100;

    logic          clock;
    logic          reset;
    logic          jogar;
    logic [NB-1:0] botoes;
    logic [15:0]   semente;
    logic          nivel;
    logic [NB-1:0] leds;
    logic          ganhou;
    logic          perdeu;
    logic          timeout;
    logic          pronto;
    logic [3:0]    db_estado;
    logic [7:0]    db_rodada;
    logic [7:0]    db_indice;

    int n_total;
    int n_ok;

    // Seed 16'h0001 sequence, stepped by hand from the LFSR recurrence.
    logic [3:0] seq1 [16];

    jogo_memoria_param #(
        .NUM_BOTOES     (NB),
        .PROFUNDIDADE   (PF),
        .TIMEOUT_CICLOS (TO),
        .MOSTRA_CICLOS  (MC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .jogar     (jogar),
        .botoes    (botoes),
        .semente   (semente),
        .nivel     (nivel),
        .leds      (leds),
        .ganhou    (ganhou),
        .perdeu    (perdeu),
        .timeout   (timeout),
        .pronto    (pronto),
        .db_estado (db_estado),
        .db_rodada (db_rodada),
        .db_indice (db_indice)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Starts a game from an idle/terminal state; returns just after MOSTRA entry.
    task automatic iniciar(input logic segura);
        jogar = 1'b1;
        tick(1);
        verifica("inicia_prepara", 32'(db_estado), 32'd1);
        if (!segura) jogar = 1'b0;
        tick(1);
        verifica("inicia_mostra", 32'(db_estado), 32'd2);
    endtask

    // Called just after MOSTRA entry; returns on the first ESPERA cycle.
    task automatic assiste(input int r, input logic chk);
        for (int i = 0; i < r; i++) begin
            if (chk) verifica($sformatf("r%0d_e%0d_aceso_ini", r, i), 32'(leds), 32'(seq1[i]));
            tick(MC - 1);
            if (chk) verifica($sformatf("r%0d_e%0d_aceso_fim", r, i), 32'(leds), 32'(seq1[i]));
            tick(1);
            if (chk) verifica($sformatf("r%0d_e%0d_apagado_ini", r, i), 32'(leds), 32'd0);
            tick(MC - 1);
            if (chk) verifica($sformatf("r%0d_e%0d_apagado_fim", r, i), 32'(leds), 32'd0);
            tick(1);
        end
        verifica($sformatf("r%0d_fim_mostra", r), 32'(db_estado), 32'd2);
        tick(1);
        verifica($sformatf("r%0d_espera", r), 32'(db_estado), 32'd3);
    endtask

    // Press and release; returns one edge after the press was registered.
    task automatic pressiona(input logic [NB-1:0] b);
        botoes = b;
        tick(1);
        botoes = '0;
        tick(1);
    endtask

    // Plays a full correct round; returns in FIM_RODADA.
    task automatic joga_rodada(input int r);
        for (int i = 0; i < r; i++) begin
            pressiona(seq1[i]);
            if (i < r - 1) verifica($sformatf("r%0d_p%0d_espera", r, i), 32'(db_estado), 32'd3);
        end
        verifica($sformatf("r%0d_fim_rodada", r), 32'(db_estado), 32'd5);
    endtask

    initial begin
        n_total = 0;
        n_ok    = 0;
        seq1 = '{4'b0010, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b1000, 4'b0100};
        reset   = 1'b0;
        jogar   = 1'b0;
        botoes  = '0;
        semente = 16'h0001;
        nivel   = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);

        verifica("rst_estado", 32'(db_estado), 32'd0);
        verifica("rst_leds", 32'(leds), 32'd0);
        verifica("rst_flags", {28'd0, ganhou, perdeu, timeout, pronto}, 32'd0);
        verifica("rst_rodada", 32'(db_rodada), 32'd0);
        verifica("rst_indice", 32'(db_indice), 32'd0);

        // Game A: seed 1, short level, held button across a round boundary.
        iniciar(1'b0);
        verifica("a_rodada1", 32'(db_rodada), 32'd1);
        assiste(1, 1'b1);
        botoes = 4'b0010;
        tick(2);
        verifica("a_r1_fim_rodada", 32'(db_estado), 32'd5);
        tick(1);
        verifica("a_r2_mostra", 32'(db_estado), 32'd2);
        for (int r = 2; r <= 8; r++) begin
            assiste(r, r == 4);
            if (r == 2) begin
                tick(5);
                verifica("a_segurado_estado", 32'(db_estado), 32'd3);
                verifica("a_segurado_indice", 32'(db_indice), 32'd0);
                botoes = '0;
                tick(1);
            end
            joga_rodada(r);
            verifica($sformatf("a_r%0d_pronto", r), 32'(pronto), 32'd0);
            tick(1);
            if (r < 8) begin
                verifica($sformatf("a_r%0d_prox_mostra", r), 32'(db_estado), 32'd2);
                verifica($sformatf("a_r%0d_prox_rodada", r), 32'(db_rodada), 32'(r + 1));
            end else begin
                verifica("a_ganhou_estado", 32'(db_estado), 32'd6);
            end
        end
        tick(1);
        verifica("a_ganhou", 32'(ganhou), 32'd1);
        verifica("a_pronto", 32'(pronto), 32'd1);
        verifica("a_perdeu", 32'(perdeu), 32'd0);

        // Game B: restart with jogar held, wrong second press in round 2.
        iniciar(1'b1);
        assiste(1, 1'b0);
        pressiona(4'b0010);
        verifica("b_r1_fim", 32'(db_estado), 32'd5);
        tick(1);
        assiste(2, 1'b0);
        pressiona(4'b0010);
        verifica("b_p0_espera", 32'(db_estado), 32'd3);
        pressiona(4'b0010);
        verifica("b_perdeu_estado", 32'(db_estado), 32'd7);
        verifica("b_perdeu_cedo", 32'(perdeu), 32'd0);
        tick(1);
        verifica("b_perdeu", 32'(perdeu), 32'd1);
        verifica("b_pronto", 32'(pronto), 32'd1);
        verifica("b_indice", 32'(db_indice), 32'd1);
        tick(3);
        verifica("b_sem_reinicio", 32'(db_estado), 32'd7);
        jogar = 1'b0;
        tick(1);

        // Game C: no press after round 1 playback.
        iniciar(1'b0);
        assiste(1, 1'b0);
        tick(TO - 1);
        verifica("c_timeout_cedo", 32'(timeout), 32'd0);
        verifica("c_timeout_estado", 32'(db_estado), 32'd8);
        tick(1);
        verifica("c_timeout", 32'(timeout), 32'd1);
        verifica("c_pronto", 32'(pronto), 32'd1);

        // Game D: two buttons at once.
        semente = 16'hACE1;
        iniciar(1'b0);
        assiste(1, 1'b0);
        pressiona(4'b0011);
        verifica("d_multi_estado", 32'(db_estado), 32'd7);
        tick(1);
        verifica("d_multi_perdeu", 32'(perdeu), 32'd1);

        // Reset in the middle of playback.
        semente = 16'h0001;
        iniciar(1'b0);
        tick(10);
        verifica("rm_leds_antes", 32'(leds), 32'b0010);
        reset = 1'b0;
        #1;
        verifica("rm_leds", 32'(leds), 32'd0);
        verifica("rm_estado", 32'(db_estado), 32'd0);
        verifica("rm_flags", {28'd0, ganhou, perdeu, timeout, pronto}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick(1);
        verifica("rm_apos", 32'(db_estado), 32'd0);

        // Game E: zero seed acts as 1; long level latched despite nivel dropping.
        semente = 16'h0000;
        nivel   = 1'b1;
        iniciar(1'b0);
        nivel = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            assiste(r, r == 12);
            joga_rodada(r);
            tick(1);
            if (r < 16) begin
                verifica($sformatf("e_r%0d_prox_mostra", r), 32'(db_estado), 32'd2);
                verifica($sformatf("e_r%0d_prox_rodada", r), 32'(db_rodada), 32'(r + 1));
            end else begin
                verifica("e_ganhou_estado", 32'(db_estado), 32'd6);
            end
        end
        tick(1);
        verifica("e_ganhou", 32'(ganhou), 32'd1);
        verifica("e_pronto", 32'(pronto), 32'd1);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised successor of `jogo_desafio_memoria`, the memory-sequence game. It generates each sequence from a seeded 16-bit LFSR instead of a fixed ROM, and plays the current prefix back on the LEDs every round. It then checks the player's button presses against that prefix, with a per-press timeout and a selectable sequence length. It sits between the board inputs (debounced buttons, switches) and the `hexa7seg` display decoders, which stay outside the block.

## Interface
- `NUM_BOTOES`, 4: buttons/LEDs; power of 2, 2..16.
- `PROFUNDIDADE`, 16: maximum sequence length; even, 2..256.
- `TIMEOUT_CICLOS`, 3000: cycles allowed per press.
- `MOSTRA_CICLOS`, 500: cycles each element is lit; also the dark gap between elements.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `jogar`  in  1  level; starts a game from INICIAL or any terminal state.
- `botoes`  in  NUM_BOTOES  debounced buttons, active-high.
- `semente`  in  16  LFSR seed, sampled when the game starts.
- `nivel`  in  1  0: sequence length PROFUNDIDADE/2; 1: sequence length PROFUNDIDADE.
- `leds`  out  NUM_BOTOES  one-hot playback; all zero outside MOSTRA.
- `ganhou`, `perdeu`, `timeout`  out  1  terminal flags.
- `pronto`  out  1  high in any terminal state.
- `db_estado`  out  4  state code.
- `db_rodada`, `db_indice`  out  8  current round length, index of the element being shown or expected.

## Operation
- Sequence element i: take the LFSR state after i steps and read its bits [log2(NUM_BOTOES)-1:0]. That value selects which button, one-hot encoded.
- LFSR step: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
- A seed of 0 is replaced by 16'h0001.
- States and codes:
  - INICIAL (0): idle; `jogar` → PREPARA.
  - PREPARA (1): latch the seed as `base`; `rodada` = 1; → MOSTRA.
  - MOSTRA (2): load `lfsr` = `base`. For k = 0..rodada-1, light element k for MOSTRA_CICLOS, then dark for MOSTRA_CICLOS. Then load `lfsr` = `base` again, index = 0 → ESPERA.
  - ESPERA (3): wait for a press. The timeout counter runs here; reaching TIMEOUT_CICLOS → TIMEOUT.
  - COMPARA (4): compare the press with element[index].
    - Mismatch → PERDEU.
    - Match, index = rodada-1 → FIM_RODADA.
    - Otherwise: index++, step the LFSR → ESPERA.
  - FIM_RODADA (5): rodada = limit → GANHOU; otherwise rodada++ → MOSTRA.
  - GANHOU (6), PERDEU (7), TIMEOUT (8): hold the matching flag and `pronto`; `jogar` → PREPARA.
- Press = rising edge of OR(`botoes`). The value is registered on that cycle.
- Zero or multiple bits set in the registered value counts as a mismatch.
- Presses are ignored outside ESPERA.
- The next press is accepted only after OR(`botoes`) has returned to 0.
- Timeout counter clears on entry to ESPERA.
- `nivel` is sampled in PREPARA only; changing it mid-game has no effect.

## Timing
- Reset: state INICIAL; all outputs 0; counters, `base` and `lfsr` cleared.
- `jogar` is sampled on the rising edge.
- INICIAL → PREPARA on the first edge with `jogar` = 1. MOSTRA begins one cycle later.
- Playback of a round of length r takes exactly 2·r·MOSTRA_CICLOS cycles, then one cycle to enter ESPERA.
- A press registered at edge t gives a COMPARA decision at edge t+1. A flag is visible at t+2.
- A press and the timeout limit on the same cycle: the press wins.
- The timeout counter is TIMEOUT_CICLOS wide enough to avoid wrap.
- `jogar` held high through a terminal state restarts once. Re-entry to PREPARA needs `jogar` low for at least one cycle.
- Reset asserted mid-game: immediate return to INICIAL with outputs 0. No partial flags.

## Structure
- Package `jogo_memoria_pkg`:
  - state enum with fixed 4-bit codes;
  - LFSR tap constant;
  - function `lfsr_passo`;
  - function `onehot`.
- Sub-module `gerador_sequencia`: holds the LFSR and `base`, with controls carrega_base, passo, and an element output.
- FSM, counters and edge detector stay in the top module.

## Test plan
- Reset mid-MOSTRA (`reset`=0 for one cycle) → `leds`=0, `db_estado`=0, all flags 0 immediately.
- Playback check, `semente`=16'h0001, NUM_BOTOES=4, `nivel`=0, PROFUNDIDADE=16:
  - round 4 lights 0010, 0100, 0001, 0001, each for 500 cycles with 500-cycle gaps;
  - full correct play → `ganhou`=1 and `pronto`=1 after round 8.
- Wrong press: same seed, round 2, press 0010 then 0010 → `perdeu`=1 two cycles after the second press; `db_indice`=1.
- Timeout: start the game, give no press after round 1 playback → `timeout`=1 exactly 3000 cycles after ESPERA entry.
- Multiple buttons: `botoes`=0011 in ESPERA → `perdeu`=1.
- Holding and length:
  - a button held across the round boundary does not count twice;
  - `semente`=0 behaves as 16'h0001;
  - `nivel`=1 needs 16 rounds before `ganhou`.
